// File: rtl/ysyx_23060111_pkg.sv
// rtl/ysyx_23060111_pkg.sv - shared state encoding, fault codes and constants for the IFU
package ysyx_23060111_pkg;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_NEXT = 3'd3,
    S_HALT = 3'd4
  } ifu_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS      = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] INST_NOP         = 32'h00000013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h80000000;

  function automatic int unsigned tmo_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ysyx_23060111_timeout_cnt.sv
// rtl/ysyx_23060111_timeout_cnt.sv - loadable saturating wait-cycle counter
// o_expired flags the cycle whose increment would reach LIMIT, so a waiter sees exactly LIMIT cycles.
module ysyx_23060111_timeout_cnt #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] W_LAST  = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_load_val > W_LIMIT) ? W_LIMIT : i_load_val;
    end else if (i_en && (r_count != W_LIMIT)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_expired = (r_count >= W_LAST);

endmodule

// File: rtl/ysyx_23060111_ifu_fsm.sv
// rtl/ysyx_23060111_ifu_fsm.sv - multi-cycle instruction fetch unit owning the architectural PC
module ysyx_23060111_ifu_fsm
  import ysyx_23060111_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned TW = tmo_width(TIMEOUT);

  ifu_state_e  r_state;
  ifu_state_e  w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_fetch_cnt;
  logic [1:0]  r_fault_cause;

  logic        w_take_npc;
  logic        w_latch_inst;
  logic        w_cnt_inc;
  logic        w_set_cause;
  logic [1:0]  w_cause;
  logic        w_tmo_clr;
  logic        w_tmo_en;
  logic        w_tmo_expired;
  logic        w_req_st;
  logic        w_out_st;

  ysyx_23060111_timeout_cnt #(
    .LIMIT (TIMEOUT),
    .WIDTH (TW)
  ) u_timeout_cnt (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_clr      (w_tmo_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_tmo_en),
    .o_expired  (w_tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take_npc   = 1'b0;
    w_latch_inst = 1'b0;
    w_cnt_inc    = 1'b0;
    w_set_cause  = 1'b0;
    w_cause      = CAUSE_NONE;
    w_tmo_clr    = 1'b0;
    w_tmo_en     = 1'b0;
    w_req_st     = 1'b0;
    w_out_st     = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_req_st = 1'b1;
        if (imem_req_ready) begin
          w_state_next = S_WAIT;
          w_tmo_clr    = 1'b1;
        end
      end
      S_WAIT: begin
        w_tmo_en = 1'b1;
        // A response landing on the expiry cycle still wins over the timeout.
        if (imem_rsp_valid && !imem_rsp_err) begin
          w_latch_inst = 1'b1;
          w_state_next = S_OUT;
        end else if (imem_rsp_valid) begin
          w_set_cause  = 1'b1;
          w_cause      = CAUSE_BUS;
          w_state_next = S_HALT;
        end else if (w_tmo_expired) begin
          w_set_cause  = 1'b1;
          w_cause      = CAUSE_TIMEOUT;
          w_state_next = S_HALT;
        end
      end
      S_OUT: begin
        w_out_st = 1'b1;
        if (out_ready) begin
          w_cnt_inc = 1'b1;
          if (npc_valid) begin
            w_take_npc = 1'b1;
          end else begin
            w_state_next = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (npc_valid) begin
          w_take_npc = 1'b1;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase

    if (w_take_npc) begin
      if (npc[1:0] == 2'b00) begin
        w_state_next = S_REQ;
      end else begin
        w_set_cause  = 1'b1;
        w_cause      = CAUSE_MISALIGN;
        w_state_next = S_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inst        <= INST_NOP;
      r_fetch_cnt   <= 32'd0;
      r_fault_cause <= CAUSE_NONE;
    end else begin
      if (w_take_npc) begin
        r_pc <= npc;
      end
      if (w_latch_inst) begin
        r_inst <= imem_rsp_data;
      end
      if (w_cnt_inc) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_set_cause) begin
        r_fault_cause <= w_cause;
      end
    end
  end

  // The REQ state is also the reset state, so the request is masked while rst is held low.
  assign imem_req_valid = w_req_st & rst;
  assign imem_addr      = r_pc;
  assign out_valid      = w_out_st;
  assign inst           = r_inst;
  assign pc             = r_pc;
  assign fault          = (r_state == S_HALT);
  assign fault_cause    = r_fault_cause;
  assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_23060111_ifu_fsm.sv
// tb/tb_ysyx_23060111_ifu_fsm.sv - directed cycle-table bench for the IFU
module tb_ysyx_23060111_ifu_fsm;

  localparam logic [31:0] P0  = 32'h80000000;
  localparam logic [31:0] P4  = 32'h80000004;
  localparam logic [31:0] P8  = 32'h80000008;
  localparam logic [31:0] PC  = 32'h8000000c;
  localparam logic [31:0] P40 = 32'h80000040;
  localparam logic [31:0] PMA = 32'h80000042;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h00100093;
  localparam logic [31:0] I1  = 32'h00200113;
  localparam logic [31:0] I2  = 32'h00300193;
  localparam logic [31:0] I9  = 32'h00009117;
  localparam logic [31:0] I3  = 32'h00000297;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'd0;
  logic        imem_rsp_err   = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = 32'd0;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060111_ifu_fsm #(
    .RESET_PC (32'h80000000),
    .TIMEOUT  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .inst           (inst),
    .pc             (pc),
    .npc_valid      (npc_valid),
    .npc            (npc),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fetch_cnt      (fetch_cnt)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        ordy;
    logic        nv;
    logic [31:0] npc;
    logic        e_rqv;
    logic        e_ov;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_f;
    logic [1:0]  e_fc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic re, input logic ordy, input logic nv,
                              input logic [31:0] nn, input logic e_rqv, input logic e_ov,
                              input logic [31:0] e_inst, input logic [31:0] e_pc,
                              input logic e_f, input logic [1:0] e_fc, input logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.ordy = ordy; v.nv = nv; v.npc = nn;
    v.e_rqv = e_rqv; v.e_ov = e_ov; v.e_inst = e_inst; v.e_pc = e_pc;
    v.e_f = e_f; v.e_fc = e_fc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;
    out_ready = 1'b0; npc_valid = 1'b0; npc = 32'd0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk({tag, ".rst_rqv"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, ".rst_ov"},  {31'd0, out_valid}, 32'd0);
    chk({tag, ".rst_pc"},  pc, P0);
    chk({tag, ".rst_inst"}, inst, NOP);
    chk({tag, ".rst_f"},   {30'd0, fault_cause}, 32'd0);
    chk({tag, ".rst_cnt"}, fetch_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n_wait;

    // rdy rv rd re ordy nv npc | rqv ov inst pc f fc cnt
    vq.push_back(mk(1, 0, 0,   0, 0, 0, 0,   1, 0, NOP, P0, 0, 0, 0));
    vq.push_back(mk(0, 1, I0,  0, 0, 0, 0,   0, 0, NOP, P0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,   0, 1, 1, P4,  0, 1, I0,  P0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0,   0, 0, 0, 0,   1, 0, I0,  P4, 0, 0, 1));
    vq.push_back(mk(0, 1, I1,  0, 0, 0, 0,   0, 0, I0,  P4, 0, 0, 1));
    vq.push_back(mk(0, 0, 0,   0, 1, 1, P8,  0, 1, I1,  P4, 0, 0, 1));
    vq.push_back(mk(1, 0, 0,   0, 0, 0, 0,   1, 0, I1,  P8, 0, 0, 2));
    vq.push_back(mk(0, 1, I2,  0, 0, 0, 0,   0, 0, I1,  P8, 0, 0, 2));
    vq.push_back(mk(0, 0, 0,   0, 1, 1, PC,  0, 1, I2,  P8, 0, 0, 2));
    vq.push_back(mk(0, 0, 0,   0, 0, 0, 0,   1, 0, I2,  PC, 0, 0, 3));
    vq.push_back(mk(0, 1, 32'hffffffff, 0, 0, 0, 0, 1, 0, I2, PC, 0, 0, 3));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, I2,  PC, 0, 0, 3));
    vq.push_back(mk(1, 0, 0,   0, 0, 0, 0,   1, 0, I2,  PC, 0, 0, 3));
    vq.push_back(mk(0, 1, I9,  0, 0, 0, 0,   0, 0, I2,  PC, 0, 0, 3));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'hdeadbeef, 0, 1, I9, PC, 0, 0, 3));
    vq.push_back(mk(0, 0, 0,   0, 1, 0, 0,   0, 1, I9,  PC, 0, 0, 3));
    vq.push_back(mk(0, 0, 0,   0, 0, 0, 0,   0, 0, I9,  PC, 0, 0, 4));
    vq.push_back(mk(0, 0, 0,   0, 0, 1, P40, 0, 0, I9,  PC, 0, 0, 4));
    vq.push_back(mk(1, 0, 0,   0, 0, 0, 0,   1, 0, I9,  P40, 0, 0, 4));
    vq.push_back(mk(0, 0, 0,   1, 0, 0, 0,   0, 0, I9,  P40, 0, 0, 4));
    vq.push_back(mk(0, 1, I3,  0, 0, 0, 0,   0, 0, I9,  P40, 0, 0, 4));
    vq.push_back(mk(0, 0, 0,   0, 1, 1, PMA, 0, 1, I3,  P40, 0, 0, 4));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1, 1, I0, 0, 1, 1, 32'h80000100, 0, 0, I3, PMA, 1, 1, 5));

    do_reset("init");
    foreach (vq[i]) begin
      imem_req_ready = vq[i].rdy; imem_rsp_valid = vq[i].rv; imem_rsp_data = vq[i].rd;
      imem_rsp_err = vq[i].re; out_ready = vq[i].ordy; npc_valid = vq[i].nv; npc = vq[i].npc;
      #1;
      chk($sformatf("row%0d.rqv", i),  {31'd0, imem_req_valid}, {31'd0, vq[i].e_rqv});
      chk($sformatf("row%0d.addr", i), imem_addr, vq[i].e_pc);
      chk($sformatf("row%0d.ov", i),   {31'd0, out_valid}, {31'd0, vq[i].e_ov});
      chk($sformatf("row%0d.inst", i), inst, vq[i].e_inst);
      chk($sformatf("row%0d.pc", i),   pc, vq[i].e_pc);
      chk($sformatf("row%0d.fault", i), {31'd0, fault}, {31'd0, vq[i].e_f});
      chk($sformatf("row%0d.cause", i), {30'd0, fault_cause}, {30'd0, vq[i].e_fc});
      chk($sformatf("row%0d.cnt", i),  fetch_cnt, vq[i].e_cnt);
      @(negedge clk);
    end

    // bus error response
    do_reset("bus");
    imem_req_ready = 1'b1;
    #1 chk("bus.rqv", {31'd0, imem_req_valid}, 32'd1);
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = I0;
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    #1;
    chk("bus.fault", {31'd0, fault}, 32'd1);
    chk("bus.cause", {30'd0, fault_cause}, 32'd2);
    chk("bus.rqv_after", {31'd0, imem_req_valid}, 32'd0);
    chk("bus.ov_after", {31'd0, out_valid}, 32'd0);

    // timeout with no response: exactly 8 wait cycles before the fault
    do_reset("tmo");
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    n_wait = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (fault !== 1'b0) break;
      n_wait++;
      @(negedge clk);
    end
    chk("tmo.wait_cycles", n_wait, 32'd8);
    chk("tmo.cause", {30'd0, fault_cause}, 32'd3);
    chk("tmo.rqv", {31'd0, imem_req_valid}, 32'd0);

    // reset pulsed while waiting on a response
    do_reset("mid");
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid.rst_rqv", {31'd0, imem_req_valid}, 32'd0);
    chk("mid.rst_pc", pc, P0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid.rqv", {31'd0, imem_req_valid}, 32'd1);
    chk("mid.addr", imem_addr, P0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = I1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("mid.ov", {31'd0, out_valid}, 32'd1);
    chk("mid.inst", inst, I1);
    chk("mid.pc", pc, P0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
